// File: rtl/comb_driver_pkg.sv
// comb_driver_pkg
// Shared constants and types for the comb_driver serial stimulus/response
// stage: frame widths, bit maps of the stim/resp buses, FSM state encoding,
// and small helpers to pack the per-block fields of those buses.
// Build option: COMB_DRIVER_PARITY_EN adds an even-parity bit to each frame.
package comb_driver_pkg;

   localparam int STIM_W = 27;
   localparam int RESP_W = 6;

`ifdef COMB_DRIVER_PARITY_EN
   localparam int FRAME_LEN = STIM_W + 1;
`else
   localparam int FRAME_LEN = STIM_W;
`endif

   // stim bit map
   localparam int STIM_U21_LSB = 0;   // [3:0]
   localparam int STIM_U31_LSB = 4;   // [9:4]
   localparam int STIM_U41_LSB = 10;  // [19:10]
   localparam int STIM_U22_LSB = 20;  // [25:20]
   localparam int STIM_U22_SEL = 26;

   // resp bit map
   localparam int RESP_U21_OUT = 0;
   localparam int RESP_U31_OUT = 1;
   localparam int RESP_U41_OUT = 2;
   localparam int RESP_U22_LSB = 3;   // [4:3]
   localparam int RESP_MUX_OUT = 5;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
   localparam logic [2:0] ST_APPLY     = 3'd2;
   localparam logic [2:0] ST_CAPTURE   = 3'd3;
   localparam logic [2:0] ST_SHIFT_OUT = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE      = ST_IDLE,
      S_SHIFT_IN  = ST_SHIFT_IN,
      S_APPLY     = ST_APPLY,
      S_CAPTURE   = ST_CAPTURE,
      S_SHIFT_OUT = ST_SHIFT_OUT
   } state_e;

   function automatic logic [STIM_W-1:0] pack_stim(input logic [3:0] u21,
                                                   input logic [5:0] u31,
                                                   input logic [9:0] u41,
                                                   input logic [5:0] u22,
                                                   input logic       sel);
      logic [STIM_W-1:0] s;
      s = '0;
      s[STIM_U21_LSB +: 4]  = u21;
      s[STIM_U31_LSB +: 6]  = u31;
      s[STIM_U41_LSB +: 10] = u41;
      s[STIM_U22_LSB +: 6]  = u22;
      s[STIM_U22_SEL]       = sel;
      return s;
   endfunction

   function automatic logic [RESP_W-1:0] pack_resp(input logic       u21,
                                                   input logic       u31,
                                                   input logic       u41,
                                                   input logic [1:0] u22,
                                                   input logic       mux);
      logic [RESP_W-1:0] r;
      r = '0;
      r[RESP_U21_OUT]      = u21;
      r[RESP_U31_OUT]      = u31;
      r[RESP_U41_OUT]      = u41;
      r[RESP_U22_LSB +: 2] = u22;
      r[RESP_MUX_OUT]      = mux;
      return r;
   endfunction

endpackage

// File: rtl/comb_driver_piso_sipo.sv
// piso_sipo
// Generic shift register with parallel load and parallel read. Shifts right:
// ser_in enters at the MSB and ser_out is the LSB, so after W shifts the
// first serial bit sits in bit 0 (LSB-first framing).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   shift_en     shift one position this cycle
//   ser_in       serial input (enters MSB)
//   load_en      load par_in (takes priority over shift_en)
//   par_in       parallel load value
//   ser_out      current LSB
//   par_out      current register contents
module piso_sipo #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         shift_en,
   input  logic         ser_in,
   input  logic         load_en,
   input  logic [W-1:0] par_in,
   output logic         ser_out,
   output logic [W-1:0] par_out
);

   logic [W-1:0] sr_q, sr_d;

   always_comb begin
      sr_d = sr_q;
      if (load_en) begin
         sr_d = par_in;
      end else if (shift_en) begin
         sr_d = {ser_in, sr_q[W-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign ser_out = sr_q[0];
   assign par_out = sr_q;

endmodule

// File: rtl/comb_driver.sv
// comb_driver
// Serial front end for the comb gate array: shifts a stimulus frame in on
// sdi, holds it on stim, waits SETTLE_CYCLES, captures resp and shifts it
// back out on sdo (both LSB first).
// Build option: COMB_DRIVER_PARITY_EN -> 28-bit frames with even parity in
// bit 27; a bad frame leaves stim untouched, sets err, and replays resp_q.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   start        begin a frame (only looked at in IDLE)
//   sdi / sdo    serial stimulus in / serial response out
//   busy, done   not-IDLE flag / one-cycle end-of-frame pulse
//   err          sticky parity error, cleared by the next accepted start
//   stim         27-bit stimulus to comb (shadow register)
//   resp         6-bit result from comb
//   resp_q       last captured result
//
// state      | meaning
// IDLE       | waiting for start
// SHIFT_IN   | sampling FRAME_LEN bits of sdi
// APPLY      | stim stable, waiting SETTLE_CYCLES for comb to settle
// CAPTURE    | latch resp into resp_q and the output shifter
// SHIFT_OUT  | driving 6 response bits on sdo
module comb_driver
   import comb_driver_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        sdi,
   output logic        sdo,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [26:0] stim,
   input  logic [5:0]  resp,
   output logic [5:0]  resp_q
);

   state_e                state_q, state_d;
   logic [4:0]            cnt_q, cnt_d;
   logic [STIM_W-1:0]     stim_q, stim_d;
   logic [RESP_W-1:0]     resp_cap_q, resp_cap_d;
   logic                  done_q, done_d;

   logic                  in_shift_en;
   logic [FRAME_LEN-2:0]  in_par;
   logic [FRAME_LEN-1:0]  frame;
   logic                  unused_in_ser;

   logic                  out_load, out_shift_en;
   logic [RESP_W-1:0]     out_par_in;
   logic [RESP_W-1:0]     unused_out_par;
   logic                  out_ser;

`ifdef COMB_DRIVER_PARITY_EN
   logic                  err_q, err_d;
`endif

   // The input shifter holds the first FRAME_LEN-1 bits; the last bit is
   // taken straight from sdi so the full frame is known in the last cycle.
   piso_sipo #(.W(FRAME_LEN - 1)) u_stim_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (in_shift_en),
      .ser_in   (sdi),
      .load_en  (1'b0),
      .par_in   ('0),
      .ser_out  (unused_in_ser),
      .par_out  (in_par)
   );

   piso_sipo #(.W(RESP_W)) u_resp_sr (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (out_shift_en),
      .ser_in   (1'b0),
      .load_en  (out_load),
      .par_in   (out_par_in),
      .ser_out  (out_ser),
      .par_out  (unused_out_par)
   );

   assign frame = {sdi, in_par};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stim_d       = stim_q;
      resp_cap_d   = resp_cap_q;
      done_d       = 1'b0;
      in_shift_en  = 1'b0;
      out_load     = 1'b0;
      out_shift_en = 1'b0;
      out_par_in   = resp;
`ifdef COMB_DRIVER_PARITY_EN
      err_d        = err_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_SHIFT_IN;
               cnt_d   = 5'(FRAME_LEN - 1);
`ifdef COMB_DRIVER_PARITY_EN
               err_d   = 1'b0;
`endif
            end
         end
         S_SHIFT_IN: begin
            in_shift_en = 1'b1;
            if (cnt_q == 5'd0) begin
`ifdef COMB_DRIVER_PARITY_EN
               if (^frame) begin
                  // bad frame: comb keeps its old stimulus, old result is replayed
                  err_d      = 1'b1;
                  out_load   = 1'b1;
                  out_par_in = resp_cap_q;
                  cnt_d      = 5'(RESP_W - 1);
                  state_d    = S_SHIFT_OUT;
               end else begin
                  stim_d  = frame[STIM_W-1:0];
                  cnt_d   = 5'(SETTLE_CYCLES - 1);
                  state_d = S_APPLY;
               end
`else
               stim_d  = frame;
               cnt_d   = 5'(SETTLE_CYCLES - 1);
               state_d = S_APPLY;
`endif
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_APPLY: begin
            if (cnt_q == 5'd0) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         S_CAPTURE: begin
            resp_cap_d = resp;
            out_load   = 1'b1;
            cnt_d      = 5'(RESP_W - 1);
            state_d    = S_SHIFT_OUT;
         end
         S_SHIFT_OUT: begin
            out_shift_en = 1'b1;
            if (cnt_q == 5'd0) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         stim_q     <= '0;
         resp_cap_q <= '0;
         done_q     <= 1'b0;
`ifdef COMB_DRIVER_PARITY_EN
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stim_q     <= stim_d;
         resp_cap_q <= resp_cap_d;
         done_q     <= done_d;
`ifdef COMB_DRIVER_PARITY_EN
         err_q      <= err_d;
`endif
      end
   end

`ifdef COMB_DRIVER_PARITY_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign sdo    = (state_q == S_SHIFT_OUT) & out_ser;
   assign busy   = (state_q != S_IDLE);
   assign done   = done_q;
   assign stim   = stim_q;
   assign resp_q = resp_cap_q;

endmodule
